mem_lsu: RTL and testbench

- Load/store unit that sits directly upstream of the data-memory port in the MEM stage.
- Takes the EX/MEM pipeline register (address, store data, mem_ctrl_t, funct3) and turns it into a req/gnt/rvalid word-bus transaction with byte enables.
- Stalls the pipeline until the transaction completes, then returns sign/zero-extended load data to WB.
- Its bus-side signals are what the memory logger and the memory block observe.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_lsu_align.sv | 42 ++++
 rtl/mem_lsu.sv | 186 ++++++++++++++++++
 tb/tb_mem_lsu.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package mem_pkg;

  typedef struct packed {
    logic rd;
    logic wr;
  } mem_ctrl_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} lsu_state_e;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] LSU_TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Unlisted funct3 encodings fall back to word size.
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: f3_size = SZ_B;
      F3_H, F3_HU: f3_size = SZ_H;
      F3_W:        f3_size = SZ_W;
      default:     f3_size = SZ_W;
    endcase
  endfunction

  function automatic logic f3_signed(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H);
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Lane steering: store byte enables / data replication and load lane extraction / extension.
module mem_lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  lsu_size_e   size_c;
  logic        sext_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    size_c  = f3_size(i_funct3);
    sext_c  = f3_signed(i_funct3);
    byte_c  = i_rdata[{i_off, 3'b000} +: 8];
    half_c  = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    case (size_c)
      SZ_B: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{sext_c & byte_c[7]}}, byte_c};
      end
      SZ_H: begin
        o_be    = 4'b0011 << i_off;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{sext_c & half_c[15]}}, half_c};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: EX/MEM access -> req/gnt/rvalid word bus, stalls until done.
// Optional watchdog abort enabled by defining LSU_TIMEOUT_EN.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TO_CNT_W       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  mem_ctrl_t   i_ctrlMEM,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_memAddr,
  input  logic [31:0] i_writeData,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_readData,
  output logic        o_misaligned,
  output logic        o_timeout,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;

  lsu_size_e   size_c;
  logic        access_c, misal_c, accept_c, rd_fire_c, to_fire_c;
  logic [3:0]  st_be_c;
  logic [31:0] st_wdata_c, ld_data_c;
  logic [31:0] unused_st_rdata, unused_ld_wdata;
  logic [3:0]  unused_ld_be;

  mem_lsu_align u_store_align (
    .i_funct3 (i_funct3),
    .i_off    (i_memAddr[1:0]),
    .i_wdata  (i_writeData),
    .i_rdata  (32'h0),
    .o_be     (st_be_c),
    .o_wdata  (st_wdata_c),
    .o_rdata  (unused_st_rdata)
  );

  mem_lsu_align u_load_align (
    .i_funct3 (f3_q),
    .i_off    (off_q),
    .i_wdata  (32'h0),
    .i_rdata  (i_bus_rdata),
    .o_be     (unused_ld_be),
    .o_wdata  (unused_ld_wdata),
    .o_rdata  (ld_data_c)
  );

  // Access qualification; reset suppresses acceptance in the same cycle.
  always_comb begin
    size_c    = f3_size(i_funct3);
    access_c  = ~i_reset & i_valid & (i_ctrlMEM.rd | i_ctrlMEM.wr);
    misal_c   = access_c & (state_q == IDLE) &
                (((size_c == SZ_H) & i_memAddr[0]) |
                 ((size_c == SZ_W) & (i_memAddr[1:0] != 2'b00)));
    accept_c  = access_c & (state_q == IDLE) & ~misal_c;
    rd_fire_c = ~we_q & i_bus_rvalid &
                (((state_q == REQ) & i_bus_gnt) | (state_q == WAIT_R));
  end

`ifdef LSU_TIMEOUT_EN
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;
  logic                timeout_q, timeout_d;

  // Watchdog fires only when the bus has not completed the access this cycle.
  always_comb begin
    to_fire_c = ((state_q == REQ) | (state_q == WAIT_R)) &
                (cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1)) &
                ~((state_q == REQ) & i_bus_gnt & (we_q | i_bus_rvalid)) &
                ~((state_q == WAIT_R) & i_bus_rvalid);
    cnt_d     = cnt_q;
    if (accept_c) cnt_d = '0;
    else if ((state_q == REQ) | (state_q == WAIT_R)) cnt_d = cnt_q + TO_CNT_W'(1);
    timeout_d = to_fire_c;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  logic unused_to;
  assign to_fire_c = 1'b0;
  assign o_timeout = 1'b0;
  assign unused_to = ^{TO_CNT_W'(TIMEOUT_CYCLES), LSU_TIMEOUT_DATA};
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = REQ;
      REQ: begin
        if (i_bus_gnt) state_d = (we_q | i_bus_rvalid) ? DONE : WAIT_R;
        else if (to_fire_c) state_d = DONE;
      end
      WAIT_R:  if (i_bus_rvalid | to_fire_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_stall      = accept_c | (state_q == REQ) | (state_q == WAIT_R);
    o_misaligned = misal_c;
    o_done       = (state_q == DONE);
    o_bus_req    = (state_q == REQ);
  end

  // Bus fields are captured at acceptance and held until the next access.
  always_comb begin
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    if (accept_c) begin
      addr_d  = {i_memAddr[31:2], 2'b00};
      we_d    = ~i_ctrlMEM.rd;
      be_d    = st_be_c;
      wdata_d = st_wdata_c;
      f3_d    = i_funct3;
      off_d   = i_memAddr[1:0];
    end
    if (rd_fire_c) rdata_d = ld_data_c;
`ifdef LSU_TIMEOUT_EN
    else if (to_fire_c) rdata_d = LSU_TIMEOUT_DATA;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      rdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_bus_addr  = addr_q;
  assign o_bus_we    = we_q;
  assign o_bus_be    = be_q;
  assign o_bus_wdata = wdata_q;
  assign o_readData  = rdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu (bus responder driven per cycle).
module tb_mem_lsu;
  import mem_pkg::*;

  logic        i_clk, i_reset, i_valid;
  mem_ctrl_t   ctrl;
  logic [2:0]  i_funct3;
  logic [31:0] i_memAddr, i_writeData;
  logic        o_stall, o_done, o_misaligned, o_timeout;
  logic [31:0] o_readData;
  logic        o_bus_req, o_bus_we;
  logic [31:0] o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_be;
  logic        i_bus_gnt, i_bus_rvalid;
  logic [31:0] i_bus_rdata;

  int n_chk = 0;
  int n_err = 0;

  mem_lsu #(.TIMEOUT_CYCLES(8)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .i_ctrlMEM    (ctrl),
    .i_funct3     (i_funct3),
    .i_memAddr    (i_memAddr),
    .i_writeData  (i_writeData),
    .o_stall      (o_stall),
    .o_done       (o_done),
    .o_readData   (o_readData),
    .o_misaligned (o_misaligned),
    .o_timeout    (o_timeout),
    .o_bus_req    (o_bus_req),
    .o_bus_we     (o_bus_we),
    .o_bus_addr   (o_bus_addr),
    .o_bus_be     (o_bus_be),
    .o_bus_wdata  (o_bus_wdata),
    .i_bus_gnt    (i_bus_gnt),
    .i_bus_rvalid (i_bus_rvalid),
    .i_bus_rdata  (i_bus_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; ctrl = '0; i_funct3 = 3'b0; i_memAddr = '0; i_writeData = '0;
    i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = '0;
  endtask

  // One access; cycle 0 is acceptance, gnt/rvalid arrive at the given cycle indices.
  task automatic run_acc(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                         input int gnt_at, input int rv_at, input logic [3:0] exp_be,
                         input logic [31:0] exp_bwd, input logic [31:0] exp_rd);
    int done_at;
    done_at = (rd ? ((rv_at > gnt_at) ? rv_at : gnt_at) : gnt_at) + 1;
    i_valid = 1'b1; ctrl.rd = rd; ctrl.wr = wr;
    i_funct3 = f3; i_memAddr = addr; i_writeData = wdata;
    for (int c = 0; c <= done_at; c++) begin
      i_bus_gnt    = (c == gnt_at);
      i_bus_rvalid = rd && (c == rv_at);
      i_bus_rdata  = (c == rv_at) ? rdata : 32'h5A5A_5A5A;
      @(negedge i_clk);
      chk({tag, "_req"},   32'(o_bus_req), 32'(c >= 1 && c <= gnt_at));
      chk({tag, "_stall"}, 32'(o_stall),   32'(c < done_at));
      chk({tag, "_done"},  32'(o_done),    32'(c == done_at));
      if (c == 1) begin
        chk({tag, "_addr"},  o_bus_addr,     {addr[31:2], 2'b00});
        chk({tag, "_we"},    32'(o_bus_we),  32'(wr && !rd));
        chk({tag, "_be"},    32'(o_bus_be),  32'(exp_be));
        chk({tag, "_wdata"}, o_bus_wdata,    exp_bwd);
      end
      if (c == done_at) chk({tag, "_rdata"}, o_readData, exp_rd);
      step();
    end
    idle_inputs();
  endtask

  task automatic run_misal(input string tag, input logic rd, input logic [2:0] f3, input logic [31:0] addr);
    i_valid = 1'b1; ctrl.rd = rd; ctrl.wr = ~rd; i_funct3 = f3; i_memAddr = addr;
    i_writeData = 32'h1111_2222; i_bus_gnt = 1'b1;
    @(negedge i_clk);
    chk({tag, "_mis"},   32'(o_misaligned), 32'd1);
    chk({tag, "_stall"}, 32'(o_stall),      32'd0);
    chk({tag, "_req"},   32'(o_bus_req),    32'd0);
    step();
    idle_inputs();
    @(negedge i_clk);
    chk({tag, "_req_after"}, 32'(o_bus_req),    32'd0);
    chk({tag, "_mis_after"}, 32'(o_misaligned), 32'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=hang exp=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int stall_hi;
    int done_seen;
    idle_inputs();
    i_reset = 1'b1;
    step(); step();
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("rst_stall", 32'(o_stall), 0);
    chk("rst_done",  32'(o_done), 0);
    chk("rst_req",   32'(o_bus_req), 0);
    chk("rst_mis",   32'(o_misaligned), 0);
    chk("rst_to",    32'(o_timeout), 0);
    chk("rst_rdata", o_readData, 0);
    chk("rst_addr",  o_bus_addr, 0);
    chk("rst_be",    32'(o_bus_be), 0);
    step();

    run_acc("sw",    1'b0, 1'b1, F3_W,  32'h104, 32'hCAFE_BABE, 32'h0, 1, 9, 4'b1111, 32'hCAFE_BABE, 32'h0);
    run_acc("sb",    1'b0, 1'b1, F3_B,  32'h203, 32'h0000_00A5, 32'h0, 1, 9, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    run_acc("lb",    1'b1, 1'b0, F3_B,  32'h102, 32'h0, 32'h0080_0000, 2, 3, 4'b0100, 32'h0, 32'hFFFF_FF80);
    run_acc("lbu",   1'b1, 1'b0, F3_BU, 32'h102, 32'h0, 32'h0080_0000, 2, 3, 4'b0100, 32'h0, 32'h0000_0080);
    run_acc("lhu",   1'b1, 1'b0, F3_HU, 32'h102, 32'h0, 32'hBEEF_1234, 1, 1, 4'b1100, 32'h0, 32'h0000_BEEF);
    run_acc("lh",    1'b1, 1'b0, F3_H,  32'h100, 32'h0, 32'h0000_8001, 1, 2, 4'b0011, 32'h0, 32'hFFFF_8001);
    run_acc("lw",    1'b1, 1'b0, F3_W,  32'h108, 32'h0, 32'h1357_9BDF, 3, 5, 4'b1111, 32'h0, 32'h1357_9BDF);
    run_acc("rw11",  1'b1, 1'b1, F3_W,  32'h10C, 32'hFFFF_FFFF, 32'h2468_ACE0, 1, 2, 4'b1111, 32'hFFFF_FFFF, 32'h2468_ACE0);
    run_acc("sh",    1'b0, 1'b1, F3_H,  32'h206, 32'h1234_ABCD, 32'h0, 2, 9, 4'b1100, 32'hABCD_ABCD, 32'h2468_ACE0);
    run_acc("f3_011",1'b1, 1'b0, 3'b011, 32'h110, 32'h0, 32'h8000_0001, 1, 1, 4'b1111, 32'h0, 32'h8000_0001);

    run_misal("lh_101", 1'b1, F3_H, 32'h101);
    run_misal("lw_102", 1'b1, F3_W, 32'h102);
    run_misal("sw_103", 1'b0, F3_W, 32'h103);
    run_misal("sh_203", 1'b0, F3_H, 32'h203);

    // Reset while a word load waits for rvalid; the late rvalid must be ignored.
    i_valid = 1'b1; ctrl.rd = 1'b1; ctrl.wr = 1'b0; i_funct3 = F3_W; i_memAddr = 32'h100;
    @(negedge i_clk);
    chk("rstw_accept_stall", 32'(o_stall), 1);
    step();
    i_bus_gnt = 1'b1;
    @(negedge i_clk);
    chk("rstw_req", 32'(o_bus_req), 1);
    step();
    i_bus_gnt = 1'b0; i_reset = 1'b1; i_valid = 1'b0;
    @(negedge i_clk);
    chk("rstw_waitr_stall", 32'(o_stall), 1);
    step();
    i_reset = 1'b0; i_bus_rvalid = 1'b1; i_bus_rdata = 32'h1234_5678;
    @(negedge i_clk);
    chk("rstw_done",  32'(o_done), 0);
    chk("rstw_stall", 32'(o_stall), 0);
    chk("rstw_req",   32'(o_bus_req), 0);
    chk("rstw_rdata", o_readData, 0);
    step();
    idle_inputs();
    @(negedge i_clk);
    chk("rstw_done2",  32'(o_done), 0);
    chk("rstw_rdata2", o_readData, 0);
    step();

    // Load whose grant never arrives.
    i_valid = 1'b1; ctrl.rd = 1'b1; ctrl.wr = 1'b0; i_funct3 = F3_W; i_memAddr = 32'h120;
    stall_hi = 0; done_seen = 0;
`ifdef LSU_TIMEOUT_EN
    for (int c = 0; c < 40 && done_seen == 0; c++) begin
      @(negedge i_clk);
      if (o_done) begin
        done_seen = 1;
        chk("to_cycle",   c, 9);
        chk("to_timeout", 32'(o_timeout), 1);
        chk("to_rdata",   o_readData, 32'hDEAD_BEEF);
      end
      step();
    end
    chk("to_done_seen", done_seen, 1);
`else
    for (int c = 0; c < 300; c++) begin
      @(negedge i_clk);
      if (o_stall) stall_hi++;
      if (o_done || o_timeout) done_seen++;
      step();
    end
    chk("hang_stall_cycles", stall_hi, 300);
    chk("hang_done_seen",    done_seen, 0);
    chk("hang_req",          32'(o_bus_req), 1);
`endif
    idle_inputs();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("final_req",   32'(o_bus_req), 0);
    chk("final_stall", 32'(o_stall), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
